// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration;
// the default build uses fixed priority (LS beats IF).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    // Only the low 32 bits of a RAM word carry payload.
    localparam logic [63:0] WORD_MASK = 64'h0000_0000_FFFF_FFFF;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner select between the IF and LS requesters.
// Build option: MEM_ARB_RR_EN selects round-robin on contention
// (winner is the requester that did not win last); otherwise LS always wins.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic if_valid,
    input  logic ls_valid,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority never looks at the grant history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick the winner from the currently valid requesters.
    always_comb begin
        grant_valid = if_valid | ls_valid;
        grant_id    = REQ_IF;
`ifdef MEM_ARB_RR_EN
        if (if_valid && ls_valid) begin
            grant_id = (last_grant == REQ_IF) ? REQ_LS : REQ_IF;
        end else if (ls_valid) begin
            grant_id = REQ_LS;
        end
`else
        if (ls_valid) begin
            grant_id = REQ_LS;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing a single-port RAM between instruction fetch (IF)
// and load/store (LS). One transaction at a time: IDLE -> ACCESS -> RESP.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration (see mem_arb_grant).
//
// Handshake: a request is accepted on the rising edge where req_valid and
// req_ready are both 1. ready is only raised in IDLE, combinationally, to the
// grant winner. A requester may drop valid before ready without effect.
// Responses are single-cycle rsp_valid pulses with no backpressure.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic              ls_req_we,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [DATA_W-1:0] ls_req_wdata,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              ls_rsp_err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output state_t            dbg_state
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t            state;
    state_t            state_next;
    logic              grant_valid;
    logic              grant_id;
    logic              last_grant;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_err;
    logic              lat_id;
    logic              lat_we;
    logic              lat_err;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rsp_word;

    mem_arb_grant u_grant (
        .if_valid    (if_req_valid),
        .ls_valid    (ls_req_valid),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign accept   = (state == ST_IDLE) && grant_valid;
    assign sel_addr = (grant_id == REQ_LS) ? ls_req_addr : if_req_addr;
    // Widened by one bit so addresses near the top of the bus cannot wrap.
    assign sel_err  = ({1'b0, sel_addr} + (ADDR_W+1)'(3)) >= LIMIT;

    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: fixed three-step walk once a request is accepted.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (grant_valid) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Capture the winning request (and grant history) on accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_id     <= REQ_IF;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            last_grant <= REQ_IF;
        end else if (accept) begin
            lat_id     <= grant_id;
            lat_we     <= (grant_id == REQ_LS) && ls_req_we;
            lat_err    <= sel_err;
            lat_addr   <= sel_addr;
            lat_wdata  <= (grant_id == REQ_LS) ? ls_req_wdata : '0;
            last_grant <= grant_id;
        end
    end

    // Outputs: ready in IDLE, RAM write strobe in ACCESS, response in RESP.
    // Everything is held at 0 while reset is asserted.
    always_comb begin
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        if_rsp_err   = 1'b0;
        ls_rsp_valid = 1'b0;
        ls_rsp_data  = '0;
        ls_rsp_err   = 1'b0;
        ram_we       = 1'b0;
        rsp_word     = '0;
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    if_req_ready = grant_valid && (grant_id == REQ_IF);
                    ls_req_ready = grant_valid && (grant_id == REQ_LS);
                end
                ST_ACCESS: begin
                    ram_we = lat_we && !lat_err;
                end
                ST_RESP: begin
                    rsp_word = (lat_we || lat_err) ? '0 : (ram_rdata & DATA_W'(WORD_MASK));
                    if (lat_id == REQ_LS) begin
                        ls_rsp_valid = 1'b1;
                        ls_rsp_data  = rsp_word;
                        ls_rsp_err   = lat_err;
                    end else begin
                        if_rsp_valid = 1'b1;
                        if_rsp_data  = rsp_word;
                        if_rsp_err   = lat_err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, checked by a negedge monitor against a behavioural byte-RAM model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int MEM = 1024;
    localparam int EXP_W = 98; // {is_ls, err, data[63:0], due_cycle[31:0]}

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [63:0] if_req_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid, ls_rsp_err;
    logic [63:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
    logic        ram_we;
    logic [63:0] ram_addr, ram_wdata, ram_rdata;
    state_t      dbg_state;

    logic        ram_clear;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [EXP_W-1:0] exp_q[$];
    bit               grant_log[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
        .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- RAM environment (1-cycle registered read) ----------------
    logic [7:0]  ram_mem [MEM];
    logic [31:0] ram_q;

    function automatic logic [31:0] rd_word(input logic [63:0] a);
        logic [31:0] w = '0;
        for (int b = 0; b < 4; b++)
            if (a + 64'(b) < 64'(MEM)) w[8*b +: 8] = ram_mem[a[9:0] + 10'(b)];
        return w;
    endfunction

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < MEM; i++) ram_mem[i] <= 8'h00;
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_addr + 64'(b) < 64'(MEM)) ram_mem[ram_addr[9:0] + 10'(b)] <= ram_wdata[8*b +: 8];
        end
        ram_q <= rd_word(ram_addr);
    end
    // Junk in the upper half makes sure the arbiter masks it off.
    assign ram_rdata = {32'hCAFE_F00D, ram_q};

    // ---------------- comparison helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard monitor ----------------
    logic [7:0]  ref_mem [MEM];
    int          free_cyc = 0;
    int          exp_we_cyc = -1;
    logic [63:0] exp_we_addr;
    logic [31:0] exp_we_data;
    bit          last_win_ls = 1'b0;

    always @(negedge clk) begin : monitor
        logic        idle, win_ls, exp_if_rdy, exp_ls_rdy, e_ls, e_err, t_we, t_err;
        logic [63:0] e_data, t_addr, t_data;
        logic [EXP_W-1:0] e;
        int          e_due;
        if (ram_clear) for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;
        if (!reset) begin
            chk("rst_if_ready", 64'(if_req_ready), 64'd0);
            chk("rst_ls_ready", 64'(ls_req_ready), 64'd0);
            chk("rst_rsp_valid", 64'({ls_rsp_valid, if_rsp_valid}), 64'd0);
            chk("rst_rsp_data", if_rsp_data | ls_rsp_data, 64'd0);
            chk("rst_rsp_err", 64'({ls_rsp_err, if_rsp_err}), 64'd0);
            chk("rst_ram_we", 64'(ram_we), 64'd0);
            exp_q.delete();
            free_cyc    = 0;
            exp_we_cyc  = -1;
            last_win_ls = 1'b0;
        end else begin
            idle = (cyc >= free_cyc);
            // Response side.
            if (if_rsp_valid || ls_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'({ls_rsp_valid, if_rsp_valid}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    e_ls = e[97]; e_err = e[96]; e_data = e[95:32]; e_due = int'(e[31:0]);
                    chk("rsp_port", 64'({ls_rsp_valid, if_rsp_valid}), e_ls ? 64'd2 : 64'd1);
                    chk("rsp_cycle", 64'(cyc), 64'(e_due));
                    chk("rsp_data", e_ls ? ls_rsp_data : if_rsp_data, e_data);
                    chk("rsp_err", 64'(e_ls ? ls_rsp_err : if_rsp_err), 64'(e_err));
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0][31:0]) <= cyc) begin
                e = exp_q.pop_front();
                chk("rsp_missing", 64'({ls_rsp_valid, if_rsp_valid}), e[97] ? 64'd2 : 64'd1);
            end
            // RAM write strobe; the reference memory is updated only when the write really happens.
            chk("ram_we", 64'(ram_we), 64'(cyc == exp_we_cyc));
            if (cyc == exp_we_cyc) begin
                chk("ram_addr", ram_addr, exp_we_addr);
                chk("ram_wdata", 64'(ram_wdata[31:0]), 64'(exp_we_data));
                for (int b = 0; b < 4; b++) ref_mem[int'(exp_we_addr) + b] = exp_we_data[8*b +: 8];
            end
            if (idle) begin
                chk("idle_state", 64'(dbg_state), 64'(ST_IDLE));
                chk("idle_rsp_data", if_rsp_data | ls_rsp_data, 64'd0);
                chk("idle_rsp_err", 64'({ls_rsp_err, if_rsp_err}), 64'd0);
            end
            // Request side: who should be granted right now.
`ifdef MEM_ARB_RR_EN
            win_ls = ls_req_valid && (!if_req_valid || !last_win_ls);
`else
            win_ls = ls_req_valid;
`endif
            exp_ls_rdy = idle && win_ls;
            exp_if_rdy = idle && if_req_valid && !win_ls;
            chk("if_ready", 64'(if_req_ready), 64'(exp_if_rdy));
            chk("ls_ready", 64'(ls_req_ready), 64'(exp_ls_rdy));
            if (ls_req_valid && ls_req_ready) grant_log.push_back(1'b1);
            else if (if_req_valid && if_req_ready) grant_log.push_back(1'b0);
            if (exp_if_rdy || exp_ls_rdy) begin
                t_addr = exp_ls_rdy ? ls_req_addr : if_req_addr;
                t_we   = exp_ls_rdy && ls_req_we;
                t_err  = (t_addr + 64'd3) >= 64'(MEM);
                t_data = '0;
                if (!t_err && !t_we)
                    for (int b = 0; b < 4; b++) t_data[8*b +: 8] = ref_mem[int'(t_addr) + b];
                if (!t_err && t_we) begin
                    exp_we_cyc  = cyc + 1;
                    exp_we_addr = t_addr;
                    exp_we_data = ls_req_wdata[31:0];
                end
                exp_q.push_back({exp_ls_rdy, t_err, t_data, 32'(cyc + 2)});
                free_cyc    = cyc + 3;
                last_win_ls = exp_ls_rdy;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input bit is_ls, input bit we, input logic [63:0] addr, input logic [63:0] wdata);
        bit got = 1'b0;
        if (is_ls) begin
            ls_req_valid = 1'b1; ls_req_we = we; ls_req_addr = addr; ls_req_wdata = wdata;
        end else begin
            if_req_valid = 1'b1; if_req_addr = addr;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = is_ls ? ls_req_ready : if_req_ready;
        end
        chk("req_accept_timeout", 64'(got), 64'd1);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 64'd1020;
            1:       return 64'(1020 + $urandom_range(1, 8));
            2:       return 64'($urandom_range(0, 60));
            default: return 64'($urandom_range(0, 15) * 4);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin : stim
        bit got, if_acc, ls_acc;
        int wait_n, base;
        bit exp_seq [4];
        if_req_valid = 1'b0; if_req_addr = '0;
        ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '0; ls_req_wdata = '0;
        ram_clear = 1'b1;
        reset = 1'b0;

        // 1: reset held with both requesters valid.
        if_req_valid = 1'b1; if_req_addr = 64'h30;
        ls_req_valid = 1'b1; ls_req_addr = 64'h20;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1; ram_clear = 1'b0;
        got = 1'b0; wait_n = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = if_req_ready | ls_req_ready;
            if (!got) wait_n++;
        end
        chk("t1_first_accept_wait", 64'(wait_n), 64'd0);
        @(posedge clk); #1;
        if_req_valid = 1'b0; ls_req_valid = 1'b0;

        // 2/3: write then read back.
        do_req(1'b1, 1'b1, 64'h10, 64'h1111_2222_DEAD_BEEF);
        do_req(1'b0, 1'b0, 64'h10, 64'h0);

        // 4: contention for four transactions (last winner was IF).
        base = grant_log.size();
        if_req_valid = 1'b1; if_req_addr = 64'h10;
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 64'h14;
        for (int i = 0; i < 40 && grant_log.size() < base + 4; i++) @(negedge clk);
        @(posedge clk); #1;
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        chk("t4_grant_count", 64'(grant_log.size() >= base + 4), 64'd1);
        for (int i = 0; i < 4; i++)
            if (grant_log.size() > base + i)
                chk($sformatf("t4_grant_%0d", i), 64'(grant_log[base + i]), 64'(exp_seq[i]));

        // 5: out-of-range write must not disturb the last in-range word.
        do_req(1'b1, 1'b1, 64'h3FC, 64'h0000_0000_1234_5678);
        do_req(1'b1, 1'b1, 64'h3FE, 64'hFFFF_FFFF_AAAA_5555);
        do_req(1'b1, 1'b0, 64'h3FC, 64'h0);

        // 6: reset during ACCESS of an LS read discards it.
        ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 64'h10;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = ls_req_ready;
        end
        chk("t6_accept", 64'(got), 64'd1);
        @(posedge clk); #1;
        ls_req_valid = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        do_req(1'b0, 1'b0, 64'h10, 64'h0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if_acc = if_req_valid && if_req_ready;
            ls_acc = ls_req_valid && ls_req_ready;
            @(posedge clk); #1;
            if (!if_req_valid || if_acc || $urandom_range(0, 7) == 0) begin
                if_req_valid = 1'($urandom_range(0, 1));
                if_req_addr  = rand_addr();
            end
            if (!ls_req_valid || ls_acc || $urandom_range(0, 7) == 0) begin
                ls_req_valid = 1'($urandom_range(0, 1));
                ls_req_we    = 1'($urandom_range(0, 1));
                ls_req_addr  = rand_addr();
                ls_req_wdata = {$urandom, $urandom};
            end
            reset = ($urandom_range(0, 199) != 0);
        end

        // Drain.
        @(posedge clk); #1;
        if_req_valid = 1'b0; ls_req_valid = 1'b0; reset = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("drain_pending", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
